bicubic_tap_sequencer: RTL

Horizontal x4 bicubic upscaler front/back end. It accepts a line of unsigned 8-bit pixels on a valid/ready stream and maintains the 4-tap window around each source pixel. For each of 4 output phases it drives sign-magnitude weight and pixel vectors onto an external `bicubic_vector_mult`, then clamps the sign-magnitude inner product back to an unsigned 8-bit output pixel. It sits between the line buffer and the vertical pass.

---
 rtl/bicubic_tap_sequencer_if.sv | 77 +++++++
 rtl/bicubic_tap_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_tap_sequencer_if.sv
// ---------------------------------------------------------------------------
// bicubic_tap_sequencer_if
//
// Bundles every non-clock signal of the bicubic tap sequencer:
//   source stream  : in_valid, in_ready, in_pixel[7:0]
//   multiplier bus : mult_weight_1..4[3:0]   (sign-magnitude weights)
//                    mult_pixel_1..4[8:0]    ({1'b0, window pixel})
//                    mult_inner_product[7:0], mult_inner_product_sign
//   output stream  : out_valid, out_ready, out_pixel[7:0], out_last
//
// The sequencer connects through the slave modport. The surrounding
// environment (line buffer, external multiplier, vertical pass) connects
// through the master modport.
// ---------------------------------------------------------------------------
interface bicubic_tap_sequencer_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;

    logic [3:0] mult_weight_1;
    logic [3:0] mult_weight_2;
    logic [3:0] mult_weight_3;
    logic [3:0] mult_weight_4;
    logic [8:0] mult_pixel_1;
    logic [8:0] mult_pixel_2;
    logic [8:0] mult_pixel_3;
    logic [8:0] mult_pixel_4;
    logic [7:0] mult_inner_product;
    logic       mult_inner_product_sign;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pixel;
    logic       out_last;

    modport slave (
        input  in_valid,
        input  in_pixel,
        output in_ready,
        output mult_weight_1,
        output mult_weight_2,
        output mult_weight_3,
        output mult_weight_4,
        output mult_pixel_1,
        output mult_pixel_2,
        output mult_pixel_3,
        output mult_pixel_4,
        input  mult_inner_product,
        input  mult_inner_product_sign,
        output out_valid,
        input  out_ready,
        output out_pixel,
        output out_last
    );

    modport master (
        output in_valid,
        output in_pixel,
        input  in_ready,
        input  mult_weight_1,
        input  mult_weight_2,
        input  mult_weight_3,
        input  mult_weight_4,
        input  mult_pixel_1,
        input  mult_pixel_2,
        input  mult_pixel_3,
        input  mult_pixel_4,
        output mult_inner_product,
        output mult_inner_product_sign,
        input  out_valid,
        output out_ready,
        input  out_pixel,
        input  out_last
    );

endinterface

// File: rtl/bicubic_tap_sequencer.sv
// ---------------------------------------------------------------------------
// bicubic_tap_sequencer
//
// Horizontal x4 bicubic upscaler front/back end. Source pixels of one line
// arrive on a valid/ready stream; a 4-tap window {p[x-1], p[x], p[x+1],
// p[x+2]} (indices clamped to the line) is kept around each source pixel.
// For each of the four output phases the window and that phase's weights
// are driven to an external multiplier, and its sign-magnitude inner product
// is clamped to an unsigned 8-bit pixel and registered onto the output
// stream.
//
// Parameters:
//   LINE_W         source pixels per line (>= 3)
//   PHASE0..PHASE3 packed weights {w1,w2,w3,w4}, each {sign, mag[2:0]}
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    bicubic_tap_sequencer_if.slave (source stream, multiplier bus,
//          output stream)
// ---------------------------------------------------------------------------
module bicubic_tap_sequencer #(
    parameter int          LINE_W = 960,
    parameter logic [15:0] PHASE0 = 16'h0700,
    parameter logic [15:0] PHASE1 = 16'hB649,
    parameter logic [15:0] PHASE2 = 16'h9559,
    parameter logic [15:0] PHASE3 = 16'h946B
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bicubic_tap_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(LINE_W + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,   // waiting for p0 of a new line
        FILL  = 3'd1,   // collecting p1, p2 before the first window is valid
        EMIT  = 3'd2,   // producing the four phases of the current window
        SHIFT = 3'd3,   // waiting for the next source pixel
        FLUSH = 3'd4    // past the line end: replicate the last pixel
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [1:0]         phase_q,     phase_d;
    logic [CNT_W-1:0]   in_cnt_q,    in_cnt_d;
    logic [1:0]         flush_cnt_q, flush_cnt_d;
    logic [7:0]         win_q [4];
    logic [7:0]         win_d [4];
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_pixel_q, out_pixel_d;
    logic               out_last_q,  out_last_d;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic        in_accept;
    logic        can_capture;
    logic        last_window;
    logic [7:0]  cap_pixel;
    logic [15:0] phase_weights;

    // Window update requests raised by the FSM and applied in one place.
    logic        do_load;
    logic        do_shift;
    logic [7:0]  shift_in;

    // Input is only taken in the states that consume source pixels; reset
    // forces in_ready low regardless of the (possibly stale) state register.
    assign bus.in_ready = rst_n &&
                          ((state_q == IDLE) || (state_q == FILL) || (state_q == SHIFT));
    assign in_accept    = bus.in_valid && bus.in_ready;

    // The output register may be overwritten when empty or being drained.
    assign can_capture  = !out_valid_q || bus.out_ready;

    // After the last source pixel, two flush shifts move the window to
    // x = LINE_W-1; that is the window whose phase-3 output ends the line.
    assign last_window  = (in_cnt_q == CNT_W'(LINE_W)) && (flush_cnt_q == 2'd2);

    // Negative products clamp to black; magnitude passes through otherwise.
    assign cap_pixel    = bus.mult_inner_product_sign ? 8'h00 : bus.mult_inner_product;

    always_comb begin
        case (phase_q)
            2'd0:    phase_weights = PHASE0;
            2'd1:    phase_weights = PHASE1;
            2'd2:    phase_weights = PHASE2;
            default: phase_weights = PHASE3;
        endcase
    end

    // The multiplier bus follows phase and window directly, so it is stable
    // whenever those are held by output backpressure.
    assign bus.mult_weight_1 = phase_weights[15:12];
    assign bus.mult_weight_2 = phase_weights[11:8];
    assign bus.mult_weight_3 = phase_weights[7:4];
    assign bus.mult_weight_4 = phase_weights[3:0];

    assign bus.mult_pixel_1  = {1'b0, win_q[0]};
    assign bus.mult_pixel_2  = {1'b0, win_q[1]};
    assign bus.mult_pixel_3  = {1'b0, win_q[2]};
    assign bus.mult_pixel_4  = {1'b0, win_q[3]};

    assign bus.out_valid     = out_valid_q;
    assign bus.out_pixel     = out_pixel_q;
    assign bus.out_last      = out_last_q;

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        in_cnt_d    = in_cnt_q;
        flush_cnt_d = flush_cnt_q;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        out_last_d  = out_last_q;
        do_load     = 1'b0;
        do_shift    = 1'b0;
        shift_in    = bus.in_pixel;

        // A presented output that is taken and not replaced empties the slot.
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (in_accept) begin
                    // p0 fills the whole window: left-edge replication.
                    do_load  = 1'b1;
                    in_cnt_d = CNT_W'(1);
                    state_d  = FILL;
                end
            end

            FILL: begin
                if (in_accept) begin
                    do_shift = 1'b1;
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    // Third accept leaves the window at {p0, p0, p1, p2}.
                    if (in_cnt_q == CNT_W'(2)) begin
                        state_d = EMIT;
                    end
                end
            end

            EMIT: begin
                if (can_capture) begin
                    out_pixel_d = cap_pixel;
                    out_valid_d = 1'b1;
                    out_last_d  = (phase_q == 2'd3) && last_window;
                    if (phase_q != 2'd3) begin
                        phase_d = phase_q + 2'd1;
                    end else begin
                        phase_d = 2'd0;
                        if (in_cnt_q < CNT_W'(LINE_W)) begin
                            state_d = SHIFT;
                        end else if (flush_cnt_q < 2'd2) begin
                            state_d = FLUSH;
                        end else begin
                            state_d     = IDLE;
                            in_cnt_d    = '0;
                            flush_cnt_d = 2'd0;
                        end
                    end
                end
            end

            SHIFT: begin
                if (in_accept) begin
                    do_shift = 1'b1;
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    state_d  = EMIT;
                end
            end

            FLUSH: begin
                // Right-edge replication: the newest tap is duplicated.
                do_shift    = 1'b1;
                shift_in    = win_q[3];
                flush_cnt_d = flush_cnt_q + 2'd1;
                state_d     = EMIT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        for (int k = 0; k < 4; k++) begin
            win_d[k] = win_q[k];
        end
        if (do_load) begin
            for (int k = 0; k < 4; k++) begin
                win_d[k] = bus.in_pixel;
            end
        end else if (do_shift) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = win_q[3];
            win_d[3] = shift_in;
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= 2'd0;
            in_cnt_q    <= '0;
            flush_cnt_q <= 2'd0;
            out_valid_q <= 1'b0;
            out_pixel_q <= 8'h00;
            out_last_q  <= 1'b0;
            // NOTE: the window is four flops rather than a RAM, so clearing
            // it in reset is cheap and keeps the mult bus defined after reset.
            for (int k = 0; k < 4; k++) begin
                win_q[k] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            in_cnt_q    <= in_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_last_q  <= out_last_d;
            for (int k = 0; k < 4; k++) begin
                win_q[k] <= win_d[k];
            end
        end
    end

endmodule
